// File: rtl/bldc_pi_controller.sv
// rtl/bldc_pi_controller.sv - sensored six-step BLDC controller with PI speed loop
//
// Purpose:
//   Decodes Hall sensors into a six-step commutation sector, drives three
//   half-bridge legs, and generates a 12-bit PWM duty from either a PI speed
//   loop or an open-loop bypass value. A 32-bit sample timer paces the speed
//   requests sent to the speed-measurement block.
//
// Ports:
//   i_clk, i_n_reset        clock, asynchronous active-low reset
//   i_enable_control        master enable (0 = outputs off, loop cleared)
//   i_rot_ccw               reverse commutation direction
//   i_bypass                open-loop duty = i_reference
//   i_reference [11:0]      speed setpoint / bypass duty
//   i_p_gain, i_i_gain [7:0] unsigned PI gains
//   i_RPM [12:0], i_valid   measured speed and its one-cycle strobe
//   i_hall_state [2:0]      Hall sensors {H3,H2,H1}
//   o_time_count [31:0]     sample timer
//   o_get_RPM               one-cycle speed request
//   o_error [14:0]          last error (signed)
//   o_p_term, o_i_term      PI terms (24-bit signed)
//   o_control_input [11:0]  PWM duty
//   o_{U,V,W}_{pos,neg}     leg enables
//   o_{U,V,W}_pwm           high-side enable gated by PWM
//   o_hall_one_hot_state    decoded sector, one-hot
//
// Configuration:
//   BLDC_HALL_SYNC_EN  adds a two-flop synchronizer and a 3-sample agreement
//                      filter on the Hall input (5-cycle Hall-to-output latency).

module bldc_pi_controller #(
  parameter int RPM_PERIOD = 1_000_000,
  parameter int GAIN_SHIFT = 8
) (
  input  logic               i_clk,
  input  logic               i_n_reset,
  input  logic               i_enable_control,
  input  logic               i_rot_ccw,
  input  logic               i_bypass,
  input  logic [11:0]        i_reference,
  input  logic [7:0]         i_p_gain,
  input  logic [7:0]         i_i_gain,
  input  logic [12:0]        i_RPM,
  input  logic               i_valid,
  input  logic [2:0]         i_hall_state,
  output logic [31:0]        o_time_count,
  output logic               o_get_RPM,
  output logic signed [14:0] o_error,
  output logic signed [23:0] o_p_term,
  output logic signed [23:0] o_i_term,
  output logic [11:0]        o_control_input,
  output logic               o_U_pos,
  output logic               o_U_neg,
  output logic               o_V_pos,
  output logic               o_V_neg,
  output logic               o_W_pos,
  output logic               o_W_neg,
  output logic               o_U_pwm,
  output logic               o_V_pwm,
  output logic               o_W_pwm,
  output logic [5:0]         o_hall_one_hot_state
);

  localparam logic [31:0]        TIMER_LAST = 32'(RPM_PERIOD - 1);
  localparam logic signed [24:0] I_MAX      = 25'sd8388607;
  localparam logic signed [24:0] I_MIN      = -25'sd8388607;
  localparam logic signed [24:0] DUTY_MAX   = 25'sd4095;

  // ---------------------------------------------------------------------------
  // Sample timer
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      o_time_count <= '0;
      o_get_RPM    <= 1'b0;
    end else if (o_time_count == TIMER_LAST) begin
      o_time_count <= '0;
      o_get_RPM    <= 1'b1;
    end else begin
      o_time_count <= o_time_count + 32'd1;
      o_get_RPM    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Hall input conditioning
  // ---------------------------------------------------------------------------
  logic [2:0] hall_use;

`ifdef BLDC_HALL_SYNC_EN
  logic [2:0] hall_sync1;
  logic [2:0] hall_sync2;
  logic [2:0] hall_hist_a;
  logic [2:0] hall_hist_b;
  logic [2:0] hall_held;

  // A new code is used only when three consecutive synchronized samples agree;
  // otherwise the last accepted code keeps driving the bridge.
  always_comb begin
    hall_use = hall_held;
    if ((hall_sync2 == hall_hist_a) && (hall_hist_a == hall_hist_b))
      hall_use = hall_sync2;
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      hall_sync1  <= '0;
      hall_sync2  <= '0;
      hall_hist_a <= '0;
      hall_hist_b <= '0;
      hall_held   <= '0;
    end else begin
      hall_sync1  <= i_hall_state;
      hall_sync2  <= hall_sync1;
      hall_hist_a <= hall_sync2;
      hall_hist_b <= hall_hist_a;
      hall_held   <= hall_use;
    end
  end
`else
  assign hall_use = i_hall_state;
`endif

  // ---------------------------------------------------------------------------
  // Sector decode and commutation. Phase masks are {W,V,U}.
  // ---------------------------------------------------------------------------
  logic [5:0] sector;
  logic [2:0] pos_cw;
  logic [2:0] neg_cw;
  logic [2:0] pos_mask;
  logic [2:0] neg_mask;

  always_comb begin
    sector = 6'b000000;
    pos_cw = 3'b000;
    neg_cw = 3'b000;
    case (hall_use)
      3'd5: begin sector = 6'b000001; pos_cw = 3'b001; neg_cw = 3'b010; end
      3'd4: begin sector = 6'b000010; pos_cw = 3'b001; neg_cw = 3'b100; end
      3'd6: begin sector = 6'b000100; pos_cw = 3'b010; neg_cw = 3'b100; end
      3'd2: begin sector = 6'b001000; pos_cw = 3'b010; neg_cw = 3'b001; end
      3'd3: begin sector = 6'b010000; pos_cw = 3'b100; neg_cw = 3'b001; end
      3'd1: begin sector = 6'b100000; pos_cw = 3'b100; neg_cw = 3'b010; end
      default: begin
        sector = 6'b000000;
        pos_cw = 3'b000;
        neg_cw = 3'b000;
      end
    endcase
  end

  // Reversing direction is a pure swap of the high/low sides in each sector.
  always_comb begin
    pos_mask = 3'b000;
    neg_mask = 3'b000;
    if (i_enable_control) begin
      pos_mask = i_rot_ccw ? neg_cw : pos_cw;
      neg_mask = i_rot_ccw ? pos_cw : neg_cw;
    end
  end

  // ---------------------------------------------------------------------------
  // PWM
  // ---------------------------------------------------------------------------
  logic [11:0] pwm_count;
  logic        pwm_on;

  // Compare against the live duty register so a new duty applies immediately.
  assign pwm_on = (pwm_count < o_control_input);

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      pwm_count            <= '0;
      o_hall_one_hot_state <= '0;
      o_U_pos              <= 1'b0;
      o_U_neg              <= 1'b0;
      o_V_pos              <= 1'b0;
      o_V_neg              <= 1'b0;
      o_W_pos              <= 1'b0;
      o_W_neg              <= 1'b0;
      o_U_pwm              <= 1'b0;
      o_V_pwm              <= 1'b0;
      o_W_pwm              <= 1'b0;
    end else begin
      pwm_count            <= pwm_count + 12'd1;
      o_hall_one_hot_state <= sector;
      o_U_pos              <= pos_mask[0];
      o_U_neg              <= neg_mask[0];
      o_V_pos              <= pos_mask[1];
      o_V_neg              <= neg_mask[1];
      o_W_pos              <= pos_mask[2];
      o_W_neg              <= neg_mask[2];
      o_U_pwm              <= pos_mask[0] & pwm_on;
      o_V_pwm              <= pos_mask[1] & pwm_on;
      o_W_pwm              <= pos_mask[2] & pwm_on;
    end
  end

  // ---------------------------------------------------------------------------
  // PI loop: error -> terms -> duty, one register stage each
  // ---------------------------------------------------------------------------
  logic               valid_d1;
  logic               valid_d2;
  logic signed [14:0] error_next;
  logic signed [23:0] p_next;
  logic signed [23:0] i_step;
  logic signed [24:0] i_sum;
  logic signed [23:0] i_next;
  logic signed [24:0] u_sum;
  logic signed [24:0] u_shift;
  logic [11:0]        u_duty;

  assign error_next = $signed({3'b000, i_reference}) - $signed({2'b00, i_RPM});

  // Gains are zero-extended so they act as positive signed multipliers.
  assign p_next = $signed({{9{o_error[14]}}, o_error}) * $signed({16'b0, i_p_gain});
  assign i_step = $signed({{9{o_error[14]}}, o_error}) * $signed({16'b0, i_i_gain});
  assign i_sum  = $signed({o_i_term[23], o_i_term}) + $signed({i_step[23], i_step});

  always_comb begin
    if (i_sum > I_MAX)
      i_next = I_MAX[23:0];
    else if (i_sum < I_MIN)
      i_next = I_MIN[23:0];
    else
      i_next = i_sum[23:0];
  end

  assign u_sum   = $signed({o_p_term[23], o_p_term}) + $signed({o_i_term[23], o_i_term});
  assign u_shift = u_sum >>> GAIN_SHIFT;

  always_comb begin
    if (u_shift < 25'sd0)
      u_duty = 12'd0;
    else if (u_shift > DUTY_MAX)
      u_duty = 12'd4095;
    else
      u_duty = u_shift[11:0];
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      valid_d1        <= 1'b0;
      valid_d2        <= 1'b0;
      o_error         <= '0;
      o_p_term        <= '0;
      o_i_term        <= '0;
      o_control_input <= '0;
    end else if (!i_enable_control) begin
      valid_d1        <= 1'b0;
      valid_d2        <= 1'b0;
      o_error         <= '0;
      o_p_term        <= '0;
      o_i_term        <= '0;
      o_control_input <= '0;
    end else begin
      // Samples in flight are dropped while bypassed so the loop state freezes.
      valid_d1 <= i_valid & ~i_bypass;
      valid_d2 <= valid_d1 & ~i_bypass;
      if (i_valid && !i_bypass)
        o_error <= error_next;
      if (valid_d1 && !i_bypass) begin
        o_p_term <= p_next;
        o_i_term <= i_next;
      end
      if (i_bypass)
        o_control_input <= i_reference;
      else if (valid_d2)
        o_control_input <= u_duty;
    end
  end

endmodule

// File: tb/tb_bldc_pi_controller.sv
// tb/tb_bldc_pi_controller.sv - directed self-checking bench for bldc_pi_controller

module tb_bldc_pi_controller;

  localparam int HALL_LAT =
`ifdef BLDC_HALL_SYNC_EN
    5;
`else
    1;
`endif

  logic               clk = 1'b0;
  logic               n_reset = 1'b0;
  logic               enable_control = 1'b0;
  logic               rot_ccw = 1'b0;
  logic               bypass = 1'b0;
  logic [11:0]        reference = '0;
  logic [7:0]         p_gain = '0;
  logic [7:0]         i_gain = '0;
  logic [12:0]        rpm = '0;
  logic               valid = 1'b0;
  logic [2:0]         hall = '0;
  logic [31:0]        time_count;
  logic               get_rpm;
  logic signed [14:0] error;
  logic signed [23:0] p_term;
  logic signed [23:0] i_term;
  logic [11:0]        control_input;
  logic               u_pos, u_neg, v_pos, v_neg, w_pos, w_neg;
  logic               u_pwm, v_pwm, w_pwm;
  logic [5:0]         one_hot;
  logic [5:0]         legs;
  logic [2:0]         pwms;

  int checks = 0;
  int errors = 0;
  int high_u;
  int high_v;

  logic [2:0] hall_seq [6];
  logic [5:0] legs_cw  [6];
  logic [5:0] legs_ccw [6];

  assign legs = {u_pos, u_neg, v_pos, v_neg, w_pos, w_neg};
  assign pwms = {u_pwm, v_pwm, w_pwm};

  always #5 clk = ~clk;

  bldc_pi_controller #(
    .RPM_PERIOD (100),
    .GAIN_SHIFT (8)
  ) dut (
    .i_clk                (clk),
    .i_n_reset            (n_reset),
    .i_enable_control     (enable_control),
    .i_rot_ccw            (rot_ccw),
    .i_bypass             (bypass),
    .i_reference          (reference),
    .i_p_gain             (p_gain),
    .i_i_gain             (i_gain),
    .i_RPM                (rpm),
    .i_valid              (valid),
    .i_hall_state         (hall),
    .o_time_count         (time_count),
    .o_get_RPM            (get_rpm),
    .o_error              (error),
    .o_p_term             (p_term),
    .o_i_term             (i_term),
    .o_control_input      (control_input),
    .o_U_pos              (u_pos),
    .o_U_neg              (u_neg),
    .o_V_pos              (v_pos),
    .o_V_neg              (v_neg),
    .o_W_pos              (w_pos),
    .o_W_neg              (w_neg),
    .o_U_pwm              (u_pwm),
    .o_V_pwm              (v_pwm),
    .o_W_pwm              (w_pwm),
    .o_hall_one_hot_state (one_hot)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] observed,
                       input logic signed [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    hall_seq = '{3'd5, 3'd4, 3'd6, 3'd2, 3'd3, 3'd1};
    // {U+,U-,V+,V-,W+,W-}
    legs_cw  = '{6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110};
    legs_ccw = '{6'b011000, 6'b010010, 6'b000110, 6'b100100, 6'b100001, 6'b001001};

    // Reset state
    tick(3);
    check("rst_time_count", time_count, 0);
    check("rst_get_rpm", get_rpm, 0);
    check("rst_control", control_input, 0);
    check("rst_legs", legs, 0);
    check("rst_one_hot", one_hot, 0);

    // Timer: first request RPM_PERIOD cycles after release, then every 100
    n_reset = 1'b1;
    tick(99);
    check("timer_99_count", time_count, 99);
    check("timer_99_pulse", get_rpm, 0);
    tick(1);
    check("timer_wrap_count", time_count, 0);
    check("timer_wrap_pulse", get_rpm, 1);
    tick(1);
    check("timer_pulse_len", get_rpm, 0);
    tick(98);
    check("timer_199_count", time_count, 99);
    tick(1);
    check("timer_wrap2_pulse", get_rpm, 1);

    // Enable with bypass, invalid Hall
    enable_control = 1'b1;
    bypass = 1'b1;
    reference = 12'h800;
    hall = 3'd0;
    tick(1);
    check("bypass_duty", control_input, 12'h800);
    tick(HALL_LAT);
    check("hall0_legs", legs, 0);
    check("hall0_one_hot", one_hot, 0);
    check("hall0_pwm", pwms, 0);

    // Hall sweep CW then CCW
    for (int i = 0; i < 6; i++) begin
      hall = hall_seq[i];
      tick(HALL_LAT);
      check($sformatf("cw_one_hot_%0d", i), one_hot, 6'd1 << i);
      check($sformatf("cw_legs_%0d", i), legs, legs_cw[i]);
    end
    rot_ccw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      hall = hall_seq[i];
      tick(HALL_LAT);
      check($sformatf("ccw_legs_%0d", i), legs, legs_ccw[i]);
    end
    hall = 3'd7;
    tick(HALL_LAT);
    check("hall7_one_hot", one_hot, 0);
    check("hall7_legs", legs, 0);

    // PWM duty 2048/4096 on U high side (sector 0, CW)
    rot_ccw = 1'b0;
    hall = 3'd5;
    tick(HALL_LAT + 1);
    high_u = 0;
    high_v = 0;
    for (int i = 0; i < 4096; i++) begin
      tick(1);
      high_u += int'(u_pwm);
      high_v += int'(v_pwm);
    end
    check("pwm_u_high_cycles", high_u, 2048);
    check("pwm_v_high_cycles", high_v, 0);

    // PI single sample
    bypass = 1'b0;
    reference = 12'd1000;
    rpm = 13'd800;
    p_gain = 8'd16;
    i_gain = 8'd2;
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    check("pi_error", error, 200);
    check("pi_duty_held", control_input, 12'h800);
    tick(1);
    check("pi_p_term", p_term, 3200);
    check("pi_i_term", i_term, 400);
    tick(1);
    check("pi_duty", control_input, 14);

    // Negative error clamps duty to 0
    reference = 12'd0;
    rpm = 13'd4000;
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    check("neg_error", error, -4000);
    tick(1);
    check("neg_p_term", p_term, -64000);
    check("neg_i_term", i_term, -7600);
    tick(1);
    check("neg_duty", control_input, 0);

    // Integrator saturation with back-to-back samples
    reference = 12'd4095;
    rpm = 13'd0;
    i_gain = 8'd255;
    valid = 1'b1;
    tick(12);
    valid = 1'b0;
    tick(3);
    check("sat_error", error, 4095);
    check("sat_p_term", p_term, 65520);
    check("sat_i_term", i_term, 8388607);
    check("sat_duty", control_input, 4095);

    // Bypass: duty follows reference, loop state frozen
    bypass = 1'b1;
    reference = 12'd100;
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    check("byp_duty", control_input, 100);
    tick(2);
    check("byp_error_hold", error, 4095);
    check("byp_i_hold", i_term, 8388607);

    // Enable dropped mid-run
    enable_control = 1'b0;
    tick(1);
    check("dis_duty", control_input, 0);
    check("dis_error", error, 0);
    check("dis_p", p_term, 0);
    check("dis_i", i_term, 0);
    check("dis_legs", legs, 0);
    check("dis_pwm", pwms, 0);
    check("dis_one_hot_keep", one_hot, 6'b000001);
    hall = 3'd4;
    tick(HALL_LAT);
    check("dis_one_hot_update", one_hot, 6'b000010);

    // Asynchronous reset during PWM
    enable_control = 1'b1;
    reference = 12'h800;
    tick(HALL_LAT + 2);
    check("pre_rst_legs", legs, 6'b100001);
    #3;
    n_reset = 1'b0;
    #1;
    check("arst_legs", legs, 0);
    check("arst_pwm", pwms, 0);
    check("arst_duty", control_input, 0);
    check("arst_one_hot", one_hot, 0);
    check("arst_time_count", time_count, 0);
    check("arst_get_rpm", get_rpm, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
